// File: rtl/nes_bus_pkg.sv
// nes_bus_pkg: shared NES bus constants and the OAM DMA state type.
package nes_bus_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_HALT, ST_ALIGN, ST_READ, ST_WRITE} dma_state_e;
   localparam logic [15:0] DMA_REG_ADDR_DEF  = 16'h4014;
   localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;
   localparam int          XFER_LEN          = 256;
endpackage

// File: rtl/oam_dma_controller.sv
// oam_dma_controller: halts the CPU and copies one 256-byte page into PPU OAM.
// Define DMA_ODD_CYCLE_ALIGN_EN to insert an ALIGN cycle when HALT lands on an odd cycle.
module oam_dma_controller
   import nes_bus_pkg::*;
#(
   parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
   parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ph2_rising,
   input  logic        ph2_falling,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_rnw,
   input  logic [7:0]  cpu_data_in,
   input  logic [7:0]  mem_data_in,
   output logic        cpu_halt,
   output logic        dma_active,
   output logic [15:0] dma_addr,
   output logic        dma_rnw,
   output logic [7:0]  dma_data_out
);
   localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);
   dma_state_e  state_q, state_d;
   logic [1:0]  rst_q;
   logic        rst_sync, trig, align, parity_q, parity_d, busy_q, busy_d, rnw_q, rnw_d;
   logic [7:0]  page_q, page_d, idx_q, idx_d, byte_q, byte_d, data_q, data_d;
   logic [15:0] addr_q, addr_d;
   logic        unused_ph2_rising;
   assign unused_ph2_rising = ph2_rising;
   // Release of rst is seen by the FSM only after two clk edges.
   always_ff @(posedge clk or posedge rst)
      if (rst) rst_q <= 2'b11;
      else rst_q <= {rst_q[0], 1'b0};
   assign rst_sync = rst_q[1];
   assign trig = state_q == ST_IDLE && !cpu_rnw && cpu_addr == DMA_REG_ADDR;
`ifdef DMA_ODD_CYCLE_ALIGN_EN
   assign align = parity_q;
`else
   assign align = 1'b0;
`endif
   always_comb begin
      state_d  = rst_sync ? ST_IDLE :
                 state_q == ST_IDLE  ? (trig ? ST_HALT : ST_IDLE) :
                 state_q == ST_HALT  ? (align ? ST_ALIGN : ST_READ) :
                 state_q == ST_ALIGN ? ST_READ :
                 state_q == ST_READ  ? ST_WRITE :
                 state_q == ST_WRITE ? (idx_q == LAST_IDX ? ST_IDLE : ST_READ) : ST_IDLE;
      page_d   = rst_sync ? 8'h00 : trig ? cpu_data_in : page_q;
      idx_d    = (rst_sync || trig) ? 8'h00 : state_q == ST_WRITE ? idx_q + 8'd1 : idx_q;
      byte_d   = rst_sync ? 8'h00 : state_q == ST_READ ? mem_data_in : byte_q;
      parity_d = !rst_sync && !parity_q;
      // Outputs are computed from the next state so they register on the same edge.
      busy_d   = state_d != ST_IDLE;
      addr_d   = state_d == ST_WRITE ? OAM_DATA_ADDR : busy_d ? {page_d, idx_d} : 16'h0000;
      rnw_d    = state_d != ST_WRITE;
      data_d   = state_d == ST_WRITE ? byte_d : 8'h00;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q  <= ST_IDLE;
         page_q   <= 8'h00;
         idx_q    <= 8'h00;
         byte_q   <= 8'h00;
         parity_q <= 1'b0;
         busy_q   <= 1'b0;
         addr_q   <= 16'h0000;
         rnw_q    <= 1'b1;
         data_q   <= 8'h00;
      end else if (ph2_falling || rst_sync) begin
         state_q  <= state_d;
         page_q   <= page_d;
         idx_q    <= idx_d;
         byte_q   <= byte_d;
         parity_q <= parity_d;
         busy_q   <= busy_d;
         addr_q   <= addr_d;
         rnw_q    <= rnw_d;
         data_q   <= data_d;
      end
   assign cpu_halt     = busy_q;
   assign dma_active   = busy_q;
   assign dma_addr     = addr_q;
   assign dma_rnw      = rnw_q;
   assign dma_data_out = data_q;
endmodule

// File: tb/tb_oam_dma_controller.sv
// tb_oam_dma_controller: table-driven and randomized checks of the OAM DMA controller.
module tb_oam_dma_controller;
   logic        clk = 1'b0, rst = 1'b1, ph2_rising = 1'b0, ph2_falling = 1'b0, cpu_rnw = 1'b1;
   logic [15:0] cpu_addr = 16'h0000;
   logic [7:0]  cpu_data_in = 8'h00, mem_data_in;
   logic        cpu_halt, dma_active, dma_rnw;
   logic [15:0] dma_addr;
   logic [7:0]  dma_data_out;
   int          checks = 0, errors = 0, falls = 0, gcnt = 0, glen = 2;
   logic        gen_en = 1'b0;
   localparam logic [26:0] IDLE_EXP = {1'b0, 1'b0, 16'h0000, 1'b1, 8'h00};

   typedef struct {
      logic [15:0] addr;
      logic        rnw;
      logic [7:0]  data;
      logic        trig;
      int          hpar;
   } vec_t;

   oam_dma_controller dut (
      .clk(clk), .rst(rst), .ph2_rising(ph2_rising), .ph2_falling(ph2_falling),
      .cpu_addr(cpu_addr), .cpu_rnw(cpu_rnw), .cpu_data_in(cpu_data_in),
      .mem_data_in(mem_data_in), .cpu_halt(cpu_halt), .dma_active(dma_active),
      .dma_addr(dma_addr), .dma_rnw(dma_rnw), .dma_data_out(dma_data_out)
   );

   always #5 clk = ~clk;

   // CPU cycles of random length (2..5 clk) with one-clk phi2 strobes.
   always @(negedge clk) begin
      if (!gen_en) begin
         ph2_rising = 1'b0;
         ph2_falling = 1'b0;
         gcnt = 0;
         glen = $urandom_range(2, 5);
      end else begin
         gcnt = gcnt + 1;
         ph2_rising = gcnt == 1;
         ph2_falling = gcnt >= glen;
         if (ph2_falling) begin
            gcnt = 0;
            glen = $urandom_range(2, 5);
         end
      end
   end

   // Memory contents: byte at {p,i} is i ^ 8'h5A ^ p ^ 8'h02 (page 2 holds i ^ 8'h5A).
   assign mem_data_in = dma_addr[7:0] ^ 8'h5A ^ dma_addr[15:8] ^ 8'h02;

   function automatic logic [7:0] src_byte(logic [7:0] p, logic [7:0] i);
      return i ^ 8'h5A ^ p ^ 8'h02;
   endfunction

   function automatic logic [26:0] obs();
      return {cpu_halt, dma_active, dma_addr, dma_rnw, dma_data_out};
   endfunction

   function automatic logic [26:0] ev(logic b, logic [15:0] a, logic r, logic [7:0] d);
      return {b, b, a, r, d};
   endfunction

   task automatic chk(string name, int k, logic [26:0] got, logic [26:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s k=%0d got %h expected %h", name, k, got, exp);
      end
   endtask

   task automatic cycle();
      int n = 0;
      @(negedge clk);
      #1;
      while (!ph2_falling && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!ph2_falling) begin
         checks++;
         errors++;
         $display("FAIL ph2_timeout got none expected strobe");
      end
      @(posedge clk);
      #1;
      falls++;
   endtask

   task automatic idle_bus();
      cpu_addr = 16'h0000;
      cpu_rnw = 1'b1;
      cpu_data_in = 8'h00;
   endtask

   task automatic random_bus();
      int r = $urandom_range(0, 3);
      cpu_data_in = 8'($urandom);
      cpu_addr = r == 0 ? 16'h4014 : r == 1 ? 16'h4015 : r == 2 ? 16'h4014 : 16'($urandom);
      cpu_rnw = r == 2 ? 1'b1 : r == 3 ? 1'($urandom) : 1'b0;
   endtask

   task automatic do_reset();
      gen_en = 1'b0;
      idle_bus();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", 0, obs(), IDLE_EXP);
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      falls = 0;
      gen_en = 1'b1;
   endtask

   // Applies one CPU bus cycle in IDLE; if it should trigger, follows the whole
   // transfer against a cycle-by-cycle list built from the transfer rules.
   task automatic apply(vec_t v, int abort_w);
      logic [26:0] q[$];
      logic        al;
      logic [7:0]  p;
      int          halted = 0, wdone = 0;
      if (v.hpar >= 0)
         while (((falls + 1) & 1) != v.hpar) begin
            idle_bus();
            cycle();
            chk("idle_pre", 0, obs(), IDLE_EXP);
         end
      cpu_addr = v.addr;
      cpu_rnw = v.rnw;
      cpu_data_in = v.data;
      cycle();
      if (!v.trig) begin
         chk("no_trigger", 0, obs(), IDLE_EXP);
         idle_bus();
         return;
      end
      p = v.data;
`ifdef DMA_ODD_CYCLE_ALIGN_EN
      al = 1'(falls & 1);
`else
      al = 1'b0;
`endif
      q.push_back(ev(1'b1, {p, 8'h00}, 1'b1, 8'h00));
      if (al) q.push_back(ev(1'b1, {p, 8'h00}, 1'b1, 8'h00));
      for (int i = 0; i < 256; i++) begin
         q.push_back(ev(1'b1, {p, 8'(i)}, 1'b1, 8'h00));
         q.push_back(ev(1'b1, 16'h2004, 1'b0, src_byte(p, 8'(i))));
      end
      q.push_back(IDLE_EXP);
      for (int k = 0; k < q.size(); k++) begin
         if (k > 0) begin
            random_bus();
            cycle();
         end
         if (cpu_halt === 1'b1) halted++;
         chk("xfer", k, obs(), q[k]);
         if (q[k][26] && !q[k][8]) wdone++;
         if (abort_w >= 0 && wdone == abort_w) begin
            @(negedge clk);
            #2;
            rst = 1'b1;
            #1;
            chk("async_rst", k, obs(), IDLE_EXP);
            do_reset();
            return;
         end
      end
      idle_bus();
      chk("halt_len", 0, 27'(halted), 27'(al ? 514 : 513));
   endtask

   initial begin
      vec_t tbl[9];
      vec_t v;
      tbl[0] = '{16'h4015, 1'b0, 8'h02, 1'b0, -1};
      tbl[1] = '{16'h4014, 1'b1, 8'h02, 1'b0, -1};
      tbl[2] = '{16'h4014, 1'b0, 8'h02, 1'b1, 1};
      tbl[3] = '{16'h0014, 1'b0, 8'h02, 1'b0, -1};
      tbl[4] = '{16'h4014, 1'b0, 8'h02, 1'b1, 0};
      tbl[5] = '{16'h2004, 1'b0, 8'h07, 1'b0, -1};
      tbl[6] = '{16'h4014, 1'b0, 8'hFF, 1'b1, -1};
      tbl[7] = '{16'h4010, 1'b0, 8'h02, 1'b0, -1};
      tbl[8] = '{16'h4014, 1'b0, 8'h00, 1'b1, -1};
      do_reset();
      for (int i = 0; i < 9; i++) apply(tbl[i], -1);
      v = '{16'h4014, 1'b0, 8'h33, 1'b1, -1};
      apply(v, 128);
      apply(v, -1);
      repeat (2) begin
         v = '{16'h4014, 1'b0, 8'($urandom), 1'b1, int'($urandom_range(0, 1))};
         apply(v, -1);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/oam_dma_controller.md
OAM_DMA_CONTROLLER -- requirements
Module: oam_dma_controller

Interface
REQ-001 SHALL have parameter DMA_REG_ADDR, default 16'h4014, meaning the CPU address whose write starts a DMA.
REQ-002 SHALL have parameter OAM_DATA_ADDR, default 16'h2004, meaning the PPU OAM data port written by each DMA write cycle.
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have ports ph2_rising and ph2_falling, input, 1 each, single-clk strobes that mark the CPU phi2 edges.
REQ-006 SHALL have ports cpu_addr (input, 16), cpu_rnw (input, 1) and cpu_data_in (input, 8), the CPU bus as the master drives it.
REQ-007 SHALL have port mem_data_in, input, 8, the read data returned by the memory manager.
REQ-008 SHALL have port cpu_halt, output, 1, the CPU RDY-low request.
REQ-009 SHALL have port dma_active, output, 1, the bus-mux select that gives the DMA address, rnw and data priority over the CPU.
REQ-010 SHALL have ports dma_addr (output, 16), dma_rnw (output, 1) and dma_data_out (output, 8), the DMA bus cycle.

Function
- One "CPU cycle" is the span between consecutive ph2_falling strobes.
- All state advances occur only on ph2_falling.
REQ-011 SHALL keep a parity bit that toggles on every ph2_falling; the bit resets to 0 (even).
REQ-012 SHALL trigger when ph2_falling is seen in IDLE with cpu_rnw=0 and cpu_addr==DMA_REG_ADDR; it latches page=cpu_data_in and moves to HALT.
REQ-013 SHALL ignore any trigger while not in IDLE.
REQ-014 SHALL define states IDLE, HALT, ALIGN, READ and WRITE.
- Transitions: IDLE->HALT on trigger.
- HALT->ALIGN or HALT->READ, per REQ-026.
- ALIGN->READ.
- READ->WRITE.
- WRITE->READ while idx!=8'hFF.
- WRITE->IDLE when idx==8'hFF.
REQ-015 SHALL assert cpu_halt and dma_active, registered, for the whole time the FSM is in HALT, ALIGN, READ or WRITE, and deassert both in IDLE.
REQ-016 SHALL, in HALT and ALIGN, drive dma_rnw=1 and dma_addr={page,idx} as dummy reads whose data is discarded.
REQ-017 SHALL, in READ, drive dma_addr={page,idx} and dma_rnw=1, and capture mem_data_in into a byte register at the closing ph2_falling.
REQ-018 SHALL, in WRITE, drive dma_addr=OAM_DATA_ADDR, dma_rnw=0 and dma_data_out=byte register, then increment idx at the closing ph2_falling.
REQ-019 SHALL keep idx 8-bit, starting at 0; dma_addr never carries into page+1, so page 8'hFF ends at 16'hFFFF.
REQ-020 SHALL hold dma_data_out at 0 outside WRITE.
REQ-021 SHALL produce exactly 256 WRITE cycles per transfer, in ascending source order.
REQ-022 SHALL take 513 halted cycles (HALT + 512) without ALIGN, or 514 with ALIGN.

Reset
REQ-023 SHALL, on rst assertion, immediately set the FSM to IDLE, idx=0, page=0, parity=0, cpu_halt=0, dma_active=0, dma_addr=0, dma_rnw=1 and dma_data_out=0.
REQ-024 SHALL abandon a transfer interrupted by reset with no further bus cycles; a later trigger restarts it from idx 0.
REQ-025 SHALL synchronise rst deassertion to clk inside the module; outputs are valid from the first ph2_falling after release.

Configuration
REQ-026 SHALL honour macro DMA_ODD_CYCLE_ALIGN_EN.
- Defined: HALT->ALIGN when parity==1 during HALT, otherwise HALT->READ, so every READ starts on an even cycle.
- Undefined: ALIGN is never entered and the transfer is always 513 cycles.

Structure
REQ-027 SHALL take the state enum, DMA_REG_ADDR/OAM_DATA_ADDR default constants and the 256-byte transfer length constant from shared package nes_bus_pkg.
REQ-028 SHALL be a single module with no sub-module; the parity counter and FSM are too small to split.

Verification
REQ-029 SHALL cover: CPU writes 8'h02 to 16'h4014 on an even cycle, memory page 2 holds i^8'h5A -> 256 writes to 16'h2004 carrying 8'h5A..(8'hFF^8'h5A) in order; cpu_halt high for 513 cycles.
REQ-030 SHALL cover, with DMA_ODD_CYCLE_ALIGN_EN defined: trigger so that HALT falls on an odd cycle -> one ALIGN cycle, cpu_halt high for 514 cycles, first READ address 16'h0200.
REQ-031 SHALL cover, with the macro undefined: the same odd-cycle trigger -> 513 cycles, ALIGN never entered.
REQ-032 SHALL cover: page 8'hFF -> last READ address 16'hFFFF; the FSM returns to IDLE with no access to 16'h0000.
REQ-033 SHALL cover: rst pulsed asynchronously after the 8'h80th WRITE -> all outputs at reset values within the same clk; a new trigger gives a full 256-write transfer from idx 0.
REQ-034 SHALL cover: writes to 16'h4015, a read of 16'h4014, and a second 16'h4014 write during a transfer -> no new trigger; cpu_halt timing unchanged.
